// File: rtl/alu_mul_sequencer.sv
// Shift-add unsigned multiplier that borrows the shared ALU one operation per cycle.
// Product is the low DATA_W bits of OpA*OpB.
//
//  state  | meaning
//  IDLE   | waiting for Start, ALU driven with a harmless pass-A of zero
//  ADD    | prod += mcand through the ALU
//  SHL    | mcand <<= 1 through the ALU
//  SHR    | mplier >>= 1 through the ALU, decide next step or finish
//  DONE   | one-cycle result strobe, then back to IDLE
module alu_mul_sequencer #(
   parameter int DATA_W   = 32,
   parameter int ITER_MAX = 32
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic [DATA_W-1:0] OpA,
   input  logic [DATA_W-1:0] OpB,
   output logic              Busy,
   output logic              Done,
   output logic [DATA_W-1:0] Product,
   output logic [DATA_W-1:0] ALU_A,
   output logic [DATA_W-1:0] ALU_B,
   output logic [4:0]        ALU_FunSel,
   output logic              ALU_WF,
   input  logic [DATA_W-1:0] ALUOut
);

   localparam logic [4:0] FS_PASS = 5'b10000;
   localparam logic [4:0] FS_ADD  = 5'b10100;
   localparam logic [4:0] FS_LSL  = 5'b11011;
   localparam logic [4:0] FS_LSR  = 5'b11100;
   localparam logic [5:0] ITER_LAST = 6'(ITER_MAX);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADD,
      S_SHL,
      S_SHR,
      S_DONE
   } state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] mcand, mcand_nxt;
   logic [DATA_W-1:0] mplier, mplier_nxt;
   logic [DATA_W-1:0] prod, prod_nxt;
   logic [5:0]        iter, iter_nxt;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state  <= S_IDLE;
         mcand  <= '0;
         mplier <= '0;
         prod   <= '0;
         iter   <= '0;
      end else begin
         state  <= state_nxt;
         mcand  <= mcand_nxt;
         mplier <= mplier_nxt;
         prod   <= prod_nxt;
         iter   <= iter_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      mcand_nxt  = mcand;
      mplier_nxt = mplier;
      prod_nxt   = prod;
      iter_nxt   = iter;
      ALU_A      = '0;
      ALU_B      = '0;
      ALU_FunSel = FS_PASS;
      case (state)
         S_IDLE: begin
            if (Start) begin
               mcand_nxt  = OpA;
               mplier_nxt = OpB;
               prod_nxt   = '0;
               iter_nxt   = '0;
               if (OpB == '0)  state_nxt = S_DONE;
               else if (OpB[0]) state_nxt = S_ADD;
               else             state_nxt = S_SHL;
            end
         end
         S_ADD: begin
            ALU_A      = prod;
            ALU_B      = mcand;
            ALU_FunSel = FS_ADD;
            prod_nxt   = ALUOut;
            state_nxt  = S_SHL;
         end
         S_SHL: begin
            ALU_A      = mcand;
            ALU_FunSel = FS_LSL;
            mcand_nxt  = ALUOut;
            state_nxt  = S_SHR;
         end
         S_SHR: begin
            ALU_A      = mplier;
            ALU_FunSel = FS_LSR;
            mplier_nxt = ALUOut;
            iter_nxt   = iter + 6'd1;
            // The iteration bound is a safety net; a nonzero multiplier always empties first.
            if (ALUOut == '0 || iter_nxt == ITER_LAST) state_nxt = S_DONE;
            else if (ALUOut[0])                        state_nxt = S_ADD;
            else                                       state_nxt = S_SHL;
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign Busy    = (state != S_IDLE);
   assign Done    = (state == S_DONE);
   assign Product = prod;
   assign ALU_WF  = 1'b0;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer with a behavioural ALU and a plain-arithmetic
// multiplier/latency reference model.
module tb_alu_mul_sequencer;

   logic        Clock, Reset, Start, Busy, Done, ALU_WF;
   logic [31:0] OpA, OpB, Product, ALU_A, ALU_B, ALUOut;
   logic [4:0]  ALU_FunSel;

   int n_checks = 0;
   int n_fail   = 0;

   alu_mul_sequencer #(.DATA_W(32), .ITER_MAX(32)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .OpA(OpA), .OpB(OpB),
      .Busy(Busy), .Done(Done), .Product(Product), .ALU_A(ALU_A), .ALU_B(ALU_B),
      .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF), .ALUOut(ALUOut)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Shared ALU as seen by the sequencer.
   always_comb begin
      case (ALU_FunSel)
         5'b10000: ALUOut = ALU_A;
         5'b10100: ALUOut = ALU_A + ALU_B;
         5'b11011: ALUOut = ALU_A << 1;
         5'b11100: ALUOut = ALU_A >> 1;
         default:  ALUOut = 32'hDEAD_BEEF;
      endcase
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_prod;
      int          exp_busy;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_prod(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] full;
      full = 64'(a) * 64'(b);
      return full[31:0];
   endfunction

   function automatic int model_busy(input logic [31:0] b);
      int h, p;
      h = 0;
      p = 0;
      if (b == 0) return 0;
      for (int i = 0; i < 32; i++)
         if (b[i]) begin
            h = i;
            p++;
         end
      return 2 * (h + 1) + p;
   endfunction

   function automatic int popcount(input logic [31:0] b);
      int p;
      p = 0;
      for (int i = 0; i < 32; i++) p += int'(b[i]);
      return p;
   endfunction

   // One multiplication; optionally pulses Start with other operands while busy.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_p, input int exp_busy, input bit pulse);
      int  busy_cyc, op_cyc, adds;
      bit  got_done;
      busy_cyc = 0;
      op_cyc   = 0;
      adds     = 0;
      got_done = 0;
      @(negedge Clock);
      Start = 1'b1;
      OpA   = a;
      OpB   = b;
      @(negedge Clock);
      Start = 1'b0;
      for (int c = 0; c < 200 && !got_done; c++) begin
         if (c > 0) @(negedge Clock);
         chk("alu_wf", 32'(ALU_WF), 32'd0);
         if (ALU_FunSel != 5'b10100) chk("alu_b_zero", ALU_B, 32'd0);
         if (Done) begin
            got_done = 1;
            Start    = 1'b0;
            chk("busy_in_done", 32'(Busy), 32'd1);
            chk("product", Product, exp_p);
         end else begin
            if (Busy) busy_cyc++;
            if (ALU_FunSel != 5'b10000) op_cyc++;
            if (ALU_FunSel == 5'b10100) adds++;
            if (pulse) begin
               Start = (busy_cyc == 3);
               OpA   = 32'd7;
               OpB   = 32'd7;
            end
         end
      end
      if (!got_done) chk("done_timeout", 32'd0, 32'd1);
      chk("busy_cycles", 32'(busy_cyc), 32'(exp_busy));
      chk("alu_op_cycles", 32'(op_cyc), 32'(exp_busy));
      chk("add_count", 32'(adds), 32'(popcount(b)));
      @(negedge Clock);
      chk("done_pulse_end", 32'(Done), 32'd0);
      chk("idle_after_done", 32'(Busy), 32'd0);
      chk("product_held", Product, exp_p);
   endtask

   initial begin
      logic [31:0] ra, rb;
      bit          seen_done;

      vecs[0] = '{32'd3,          32'd5,          32'd15,         8};
      vecs[1] = '{32'h1234_5678,  32'd0,          32'd0,          0};
      vecs[2] = '{32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  5};
      vecs[3] = '{32'h0001_0000,  32'h0001_0000,  32'd0,          35};
      vecs[4] = '{32'd1,          32'h8000_0001,  32'h8000_0001,  66};
      vecs[5] = '{32'd6,          32'd7,          32'd42,         9};

      Reset = 1'b0;
      Start = 1'b0;
      OpA   = '0;
      OpB   = '0;
      #3;
      chk("rst_busy",   32'(Busy), 32'd0);
      chk("rst_done",   32'(Done), 32'd0);
      chk("rst_prod",   Product, 32'd0);
      chk("rst_alu_a",  ALU_A, 32'd0);
      chk("rst_alu_b",  ALU_B, 32'd0);
      chk("rst_funsel", 32'(ALU_FunSel), 32'h10);
      chk("rst_wf",     32'(ALU_WF), 32'd0);
      @(negedge Clock);
      Reset = 1'b1;

      foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp_prod, vecs[i].exp_busy, 1'b0);

      // Start pulsed mid-operation must not disturb the running multiply.
      run_op(32'd6, 32'd7, 32'd42, 9, 1'b1);

      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         if (i % 5 == 0) rb = rb & 32'h0101_0101;
         run_op(ra, rb, model_prod(ra, rb), model_busy(rb), 1'b0);
      end

      // Held Start re-triggers on the first IDLE cycle after DONE.
      @(negedge Clock);
      Start = 1'b1;
      OpA   = 32'd2;
      OpB   = 32'd3;
      seen_done = 0;
      for (int c = 0; c < 50 && !seen_done; c++) begin
         @(negedge Clock);
         seen_done = Done;
      end
      chk("hold_done", 32'(seen_done), 32'd1);
      chk("hold_prod", Product, 32'd6);
      @(negedge Clock);
      chk("hold_idle_gap", 32'(Busy), 32'd0);
      OpA = 32'd4;
      OpB = 32'd1;
      @(negedge Clock);
      chk("hold_retrigger", 32'(Busy), 32'd1);
      Start = 1'b0;
      seen_done = 0;
      for (int c = 0; c < 50 && !seen_done; c++) begin
         @(negedge Clock);
         seen_done = Done;
      end
      chk("retrig_done", 32'(seen_done), 32'd1);
      chk("retrig_prod", Product, 32'd4);

      // Reset asserted while in SHL aborts without a Done pulse.
      @(negedge Clock);
      @(negedge Clock);
      Start = 1'b1;
      OpA   = 32'd5;
      OpB   = 32'd3;
      @(negedge Clock);
      Start = 1'b0;
      chk("pre_rst_funsel_add", 32'(ALU_FunSel), 32'h14);
      @(negedge Clock);
      chk("pre_rst_funsel_shl", 32'(ALU_FunSel), 32'h1B);
      chk("pre_rst_prod", Product, 32'd5);
      #1 Reset = 1'b0;
      #1;
      chk("midrst_busy",   32'(Busy), 32'd0);
      chk("midrst_done",   32'(Done), 32'd0);
      chk("midrst_prod",   Product, 32'd0);
      chk("midrst_alu_a",  ALU_A, 32'd0);
      chk("midrst_funsel", 32'(ALU_FunSel), 32'h10);
      seen_done = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge Clock);
         seen_done = seen_done | Done;
      end
      Reset = 1'b1;
      @(negedge Clock);
      seen_done = seen_done | Done;
      chk("midrst_no_done", 32'(seen_done), 32'd0);
      run_op(32'd6, 32'd7, 32'd42, 9, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
